// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD add/subtract unit.
// Op encodings, FSM state type and the per-digit nines' complement helper.
package bcd_pkg;

    localparam int DIG_W = 4;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic logic [DIG_W-1:0] nines(input logic [DIG_W-1:0] d);
        return 4'd9 - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: x + y + cin with decimal adjust.
// Purely combinational; inputs are assumed to be valid digits (0..9).
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] x,
    input  logic [DIG_W-1:0] y,
    input  logic             cin,
    output logic [DIG_W-1:0] digit,
    output logic             cout
);

    logic [DIG_W:0] sum;
    logic [DIG_W:0] sum_adj;

    always_comb begin
        sum     = {1'b0, x} + {1'b0, y} + {{DIG_W{1'b0}}, cin};
        sum_adj = sum;
        cout    = 1'b0;
        if (sum > 5'd9) begin
            sum_adj = sum + 5'd6;
            cout    = 1'b1;
        end
        digit = sum_adj[DIG_W-1:0];
    end

endmodule

// File: rtl/bcd_alu_seq.sv
// Digit-serial packed-BCD add/subtract, LSD first, one digit per clock.
// Results are built by shifting digits in at the MSD end of the result register.
module bcd_alu_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [4*NDIG-1:0]     a,
    input  logic [4*NDIG-1:0]     b,
    output logic                  ready,
    output logic                  done,
    output logic [4*NDIG-1:0]     result,
    output logic                  neg,
    output logic                  ovf,
    output logic                  err
);

    localparam int W  = DIG_W * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sub_q, sub_d;
    logic          cy_q, cy_d;
    logic          neg_q, neg_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic             bad_nibble;
    logic             op_ok;
    logic [DIG_W-1:0] x_dig, y_dig, sum_dig;
    logic             sum_cy;
    logic [W-1:0]     res_shift;

    always_comb begin
        bad_nibble = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[i*DIG_W +: DIG_W] > 4'd9 || b[i*DIG_W +: DIG_W] > 4'd9)
                bad_nibble = 1'b1;
        end
    end

    assign op_ok = (op == OP_ADD) || (op == OP_SUB);

    // FIX reuses the adder to form the ten's complement of the partial result.
    assign x_dig = (state_q == ST_FIX) ? nines(res_q[DIG_W-1:0]) : a_q[DIG_W-1:0];
    assign y_dig = (state_q == ST_FIX) ? '0
                 : (sub_q ? nines(b_q[DIG_W-1:0]) : b_q[DIG_W-1:0]);

    bcd_digit_add u_dig (
        .x     (x_dig),
        .y     (y_dig),
        .cin   (cy_q),
        .digit (sum_dig),
        .cout  (sum_cy)
    );

    assign res_shift = (res_q >> DIG_W) | (W'(sum_dig) << (W - DIG_W));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        cy_d    = cy_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    sub_d = (op == OP_SUB);
                    cy_d  = (op == OP_SUB);
                    res_d = '0;
                    cnt_d = '0;
                    neg_d = 1'b0;
                    ovf_d = 1'b0;
                    err_d = 1'b0;
                    if (!op_ok || bad_nibble) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                a_d   = a_q >> DIG_W;
                b_d   = b_q >> DIG_W;
                res_d = res_shift;
                cy_d  = sum_cy;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (!sub_q) begin
                        ovf_d   = sum_cy;
                        state_d = ST_DONE;
                    end else if (sum_cy) begin
                        state_d = ST_DONE;
                    end else begin
                        // No end-around carry means A<B: complement the digits.
                        neg_d   = 1'b1;
                        cy_d    = 1'b1;
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                res_d = res_shift;
                cy_d  = sum_cy;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            cy_q    <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            cy_q    <= cy_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = res_q;
    assign neg    = neg_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

endmodule
